// File: rtl/mul_sched_pkg.sv
// mul_sched_pkg: shared id-width helper and the valid+id tag carried alongside the multiplier
package mul_sched_pkg;
  localparam int MAX_IDW = 4;
  function automatic int idw(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  typedef struct packed {
    logic valid;
    logic [MAX_IDW-1:0] id;
  } tag_t;
endpackage

// File: rtl/mul_pipe_scheduler_if.sv
// mul_pipe_scheduler_if: requester bus (req_valid/ready/a/b in, res_valid/id/data and busy out); master = requesters, slave = scheduler
interface mul_pipe_scheduler_if
  import mul_sched_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREQ = 4,
  parameter int IDW = idw(NREQ)
);
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic res_valid;
  logic [IDW-1:0] res_id;
  logic [WIDTH-1:0] res_data;
  logic busy;
  modport master(output req_valid, req_a, req_b, input req_ready, res_valid, res_id, res_data, busy);
  modport slave(input req_valid, req_a, req_b, output req_ready, res_valid, res_id, res_data, busy);
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin pick from req starting at ptr (wrapping); ports req/ptr in, one-hot-or-zero grant and its idx out
module rr_arbiter
  import mul_sched_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = idw(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) if (req[i]) idx = IW'(i);
    for (int i = N - 1; i >= 0; i--) if (req[i] && IW'(i) >= ptr) idx = IW'(i);
    grant = |req ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/mul_pipe_scheduler.sv
// mul_pipe_scheduler: shares one fixed-latency multiplier among NREQ requesters; ports clk/reset, bus (slave), mul_a/mul_b out, mul_y in
module mul_pipe_scheduler
  import mul_sched_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREQ = 4,
  parameter int LATENCY = 32,
  parameter int MAX_OUT = 8
) (
  input  logic             clk,
  input  logic             reset,
  mul_pipe_scheduler_if.slave bus,
  output logic [WIDTH-1:0] mul_a,
  output logic [WIDTH-1:0] mul_b,
  input  logic [WIDTH-1:0] mul_y
);
  localparam int IDW = idw(NREQ);
  localparam int CW = $clog2(MAX_OUT + 1);
  logic [CW-1:0] cnt [NREQ];
  logic [IDW-1:0] ptr, sel;
  logic [NREQ-1:0] eligible, grant, ret;
  logic [WIDTH-1:0] a_sel, b_sel;
  tag_t tags [LATENCY+1];
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      eligible[i] = bus.req_valid[i] && cnt[i] < CW'(MAX_OUT);
      ret[i] = bus.res_valid && tags[LATENCY].id == MAX_IDW'(i);
      if (grant[i]) begin
        a_sel = bus.req_a[i*WIDTH +: WIDTH];
        b_sel = bus.req_b[i*WIDTH +: WIDTH];
      end
    end
  end
  rr_arbiter #(.N(NREQ)) u_arb (.req(eligible), .ptr, .grant, .idx(sel));
  assign bus.req_ready = reset ? '0 : grant;
  assign bus.res_valid = tags[LATENCY].valid;
  assign bus.res_id = tags[LATENCY].id[IDW-1:0];
  assign bus.res_data = mul_y;
  always_comb begin
    bus.busy = 1'b0;
    for (int i = 0; i <= LATENCY; i++) bus.busy = bus.busy | tags[i].valid;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      mul_a <= '0;
      mul_b <= '0;
      ptr <= '0;
      for (int i = 0; i <= LATENCY; i++) tags[i] <= '0;
      for (int i = 0; i < NREQ; i++) cnt[i] <= '0;
    end else begin
      mul_a <= a_sel;
      mul_b <= b_sel;
      tags[0] <= '{valid: |grant, id: MAX_IDW'(sel)};
      for (int i = 1; i <= LATENCY; i++) tags[i] <= tags[i-1];
      if (|grant) ptr <= sel == IDW'(NREQ - 1) ? '0 : sel + 1'b1;
      for (int i = 0; i < NREQ; i++) cnt[i] <= cnt[i] + CW'(grant[i]) - CW'(ret[i]);
    end
  end
endmodule

// File: doc/mul_pipe_scheduler.md
Name: mul_pipe_scheduler

Overview:
Shares one array_multiplier_pipeline instance (fixed LATENCY, one issue per clock, no internal valid/stall) among NREQ requesters. Each cycle, a round-robin arbiter accepts at most one operand pair. The block carries a valid+ID tag pipeline alongside the multiplier and returns each product tagged with the originating requester. A per-requester outstanding-operation cap bounds the response buffering each requester needs.

Parameters:
WIDTH, 32, operand and product width (product = low WIDTH bits of a*b, same as multiplier y)
NREQ, 4, number of requesters (2..16)
LATENCY, 32, clock edges from operands presented on mul_a/mul_b to matching mul_y valid; must equal the multiplier instance's depth
MAX_OUT, 8, max in-flight operations per requester (1..LATENCY+1)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
req_valid  in  NREQ  per-requester operation request
req_ready  out  NREQ  one-hot-or-zero grant; transfer on req_valid[i]&req_ready[i] at clock edge
req_a  in  NREQ*WIDTH  flattened operands a, requester i at [i*WIDTH +: WIDTH]
req_b  in  NREQ*WIDTH  flattened operands b, same packing
mul_a  out  WIDTH  registered operand a to the multiplier
mul_b  out  WIDTH  registered operand b to the multiplier
mul_y  in  WIDTH  multiplier product
res_valid  out  1  product valid this cycle (no backpressure; the consumer must take it)
res_id  out  IDW  requester index of the product, IDW = max(1,$clog2(NREQ))
res_data  out  WIDTH  product; mul_y passed through combinationally
busy  out  1  any operation in flight

Behaviour:
- Reset values: mul_a=0, mul_b=0, tag pipeline all invalid, res_valid=0, res_id=0, busy=0, all outstanding counters 0, RR pointer=0. req_ready is combinational; it is 0 while reset is high.
- Eligibility: eligible[i] = req_valid[i] & (cnt[i] < MAX_OUT).
- Arbitration: combinational round-robin. Search starts at the pointer index and wraps modulo NREQ. The first eligible requester gets req_ready. At most one bit set. Never assert req_ready without req_valid.
- Pointer update on an accepted transfer from i: pointer <= (i+1) mod NREQ. No transfer: pointer holds.
- Issue at edge E: mul_a/mul_b <= selected req_a/req_b. Tag stage 0 <= {1, i}. No transfer: mul_a/mul_b <= 0 and tag stage 0 <= invalid.
- Tag pipeline: LATENCY stages, shifts every cycle, no stall. res_valid/res_id are the last stage. The product of an op accepted at edge E is presented with res_valid=1 in the cycle after edge E+LATENCY. Throughput is 1 op/cycle sustained.
- res_data = mul_y at all times. It is only meaningful when res_valid=1.
- Outstanding counters: cnt[i] +1 on transfer from i, -1 when res_valid & res_id==i. Both in the same cycle: unchanged. cnt never exceeds MAX_OUT and never underflows.
- Cap boundary: a requester at cnt==MAX_OUT is skipped. If its own response returns in that cycle, it is still skipped this cycle (the cap uses the registered count) and becomes eligible next cycle.
- busy = OR of tag-stage valids.
- Reset mid-operation: all in-flight tags dropped. res_valid=0 from the cycle after the reset edge. Counters cleared. Products still emerging from the multiplier are ignored.
- Requests held without grant must keep req_a/req_b stable. The block does not latch operands until transfer.

Decomposition:
- Shared package mul_sched_pkg: IDW computation function, tag struct {valid, id}.
- One natural sub-module: rr_arbiter (NREQ request vector + pointer in, one-hot grant + index out). It is reused elsewhere.
- The multiplier is instantiated by the parent, not inside this block.

Test Plan:
- Single op: reset 2 cycles, requester 2 sends a=7, b=6 -> exactly one cycle of res_valid=1 with res_id=2 and res_data=42, exactly LATENCY cycles after acceptance. busy high during flight only.
- Fairness: all 4 requesters hold req_valid for 8 cycles -> grants in order 0,1,2,3,0,1,2,3. Responses appear in the same order, back-to-back.
- Cap: MAX_OUT=2, requester 1 alone holds valid -> 2 grants, then req_ready[1]=0 until the first response cycle. Regrant follows on the next cycle, and cnt stays within 0..2.
- Wrap/overflow: a=32'hFFFFFFFF, b=32'h2 -> res_data=32'hFFFFFFFE. Random xorshift32 operands for 100 ops match a*b mod 2^32.
- Idle gaps: sparse requests with 0-5 idle cycles -> res_valid never asserted spuriously, and mul_a/mul_b=0 on idle cycles.
- Reset mid-flight: issue 5 ops, assert reset for 1 cycle at op-3 + 10 cycles -> no res_valid afterwards, busy=0, counters 0. A fresh op then completes normally.
